// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp program loader: loader FSM states and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mpp_pkg;

    // Loader sequencing: two header bytes (length, big-endian), payload, checksum.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5
    } ld_state_e;

    // Number of length-header bytes that precede the payload.
    localparam int HDR_LEN = 2;

    // Byte returned for fetches outside the implemented memory or while held.
    localparam logic [7:0] FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/mpp_prog_ram.sv
// Byte-wide program RAM, one write port and one read port, depth 2**ADDR_W.
// Latency: read data registered, valid the cycle after re_i; writes land on the edge.
// Backpressure: none; rdata_o holds its last value while re_i is low.
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request; rdata_o read data.
module mpp_prog_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rdata_q;

    // Storage is deliberately not reset: an aborted load leaves its bytes behind.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mpp_prog_loader.sv
// Program memory plus byte-serial boot loader feeding the mpp core's instruction fetch.
// Latency: fetch data one cycle after program_cs_n low; load status one cycle after checksum byte.
// Backpressure: load_ready high only while expecting header/data/checksum bytes.
// Ports: clk, rst_n; program_cs_n/program_addr -> instruction (fetch);
//        load_start, load_data/load_valid/load_ready (image stream); cpu_hold, load_done, load_error (status).
module mpp_prog_loader
    import mpp_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] FILL   = FILL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        program_cs_n,
    input  logic [15:0] program_addr,
    output logic [7:0]  instruction,
    input  logic        load_start,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    ld_state_e   state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  csum_q, csum_d;
    logic        ovf_q, ovf_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        fill_sel_q;

    logic        accept;
    logic        wr_in_range;
    logic        ram_we;
    logic [7:0]  csum_total;
    logic        rd_ok;
    logic [7:0]  ram_rdata;

    assign load_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                        (state_q == ST_DATA)   || (state_q == ST_CSUM);

    // A restart wins over a byte offered on the same edge; that byte is dropped.
    assign accept      = load_valid && load_ready && !load_start;
    assign wr_in_range = (wr_addr_q[15:ADDR_W] == '0);
    assign csum_total  = csum_q + load_data;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_addr_d = wr_addr_q;
        csum_d    = csum_q;
        ovf_d     = ovf_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        ram_we    = 1'b0;

        if (load_start) begin
            state_d   = ST_LEN_HI;
            len_d     = '0;
            wr_addr_d = '0;
            csum_d    = '0;
            ovf_d     = 1'b0;
            hold_d    = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else if (accept) begin
            case (state_q)
                ST_LEN_HI: begin
                    len_d   = {load_data, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d   = {len_q[15:8], load_data};
                    state_d = ({len_q[15:8], load_data} == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    // Bytes beyond the implemented depth still count toward the checksum.
                    ram_we    = wr_in_range;
                    ovf_d     = ovf_q || !wr_in_range;
                    csum_d    = csum_total;
                    wr_addr_d = wr_addr_q + 16'd1;
                    if (wr_addr_q == len_q - 16'd1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_d = ST_DONE;
                    if (csum_total == 8'h00 && !ovf_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            wr_addr_q <= '0;
            csum_q    <= '0;
            ovf_q     <= 1'b0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_addr_q <= wr_addr_d;
            csum_q    <= csum_d;
            ovf_q     <= ovf_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

    // Writes only occur while the core is held, so a fetch can never observe
    // a byte mid-write: held fetches are steered to FILL instead of the RAM.
    assign rd_ok = !program_cs_n && (program_addr[15:ADDR_W] == '0) && !hold_q;

    // The RAM read register is not reset, so a flag remembers whether the
    // last fetch should present FILL; together they form the instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_sel_q <= 1'b1;
        end else if (!program_cs_n) begin
            fill_sel_q <= !rd_ok;
        end
    end

    mpp_prog_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_addr_q[ADDR_W-1:0]),
        .wdata_i (load_data),
        .re_i    (rd_ok),
        .raddr_i (program_addr[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign instruction = fill_sel_q ? FILL : ram_rdata;

endmodule

// File: tb/tb_mpp_prog_loader.sv
// Scoreboard bench for mpp_prog_loader with a 16-byte memory (ADDR_W = 4).
// Stimulus pushes expected fetch bytes from a byte-array model; a monitor pops on each fetch.
// Load status is compared against the model after each checksum byte.
module tb_mpp_prog_loader;

    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] FILLV = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        program_cs_n;
    logic [15:0] program_addr;
    logic [7:0]  instruction;
    logic        load_start;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    mpp_prog_loader #(
        .ADDR_W (AW),
        .FILL   (FILLV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .program_cs_n (program_cs_n),
        .program_addr (program_addr),
        .instruction  (instruction),
        .load_start   (load_start),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [DEPTH];
    bit         m_hold = 1'b1;
    bit         m_done = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] last_instr = FILLV;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every fetch strobe seen at a rising edge yields one output byte
    // at the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && program_cs_n === 1'b0) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL fetch_unexpected: got %0h expected none", instruction);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("fetch", 32'(instruction), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_fetch(input logic [15:0] a);
        if (a < 16'(DEPTH) && !m_hold) return mem_m[a[3:0]];
        return FILLV;
    endfunction

    task automatic fetch(input logic [15:0] a);
        @(negedge clk);
        program_cs_n = 1'b0;
        program_addr = a;
        last_instr   = exp_fetch(a);
        exp_q.push_back(last_instr);
    endtask

    task automatic fetch_end();
        @(negedge clk);
        program_cs_n = 1'b1;
        program_addr = 16'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        load_valid = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom);
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        m_hold = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
        check("start_ready", 32'(load_ready), 32'd1);
        check("start_hold",  32'(cpu_hold),   32'd1);
        check("start_done",  32'(load_done),  32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        load_valid = 1'b1;
        load_data  = b;
        while (load_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got load_ready=%0b expected 1", load_ready);
            load_valid = 1'b0;
            return;
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic send_header(input int n);
        logic [15:0] len;
        len = 16'(n);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic run_load(input logic [7:0] d[$], input logic [7:0] cs);
        logic [7:0] sum;
        bit         ok;
        sum = 8'h00;
        pulse_start();
        send_header(d.size());
        foreach (d[i]) begin
            send_byte(d[i]);
            if (i < DEPTH) mem_m[i] = d[i];
            sum = sum + d[i];
        end
        send_byte(cs);
        ok = (8'(sum + cs) == 8'h00) && (d.size() <= DEPTH);
        m_done = ok;
        m_err  = !ok;
        m_hold = !ok;
        check("load_done",  32'(load_done),  32'(m_done));
        check("load_error", 32'(load_error), 32'(m_err));
        check("cpu_hold",   32'(cpu_hold),   32'(m_hold));
        check("done_ready", 32'(load_ready), 32'd0);
    endtask

    // Starts a load and stops after k data bytes, leaving the loader mid-DATA.
    task automatic partial_load(input logic [7:0] d[$], input int k);
        pulse_start();
        send_header(d.size());
        for (int i = 0; i < k; i++) begin
            send_byte(d[i]);
            if (i < DEPTH) mem_m[i] = d[i];
        end
    endtask

    logic [7:0] img[$];
    logic [7:0] empty_img[$];
    logic [7:0] rsum;
    logic [7:0] rcs;

    initial begin
        rst_n        = 1'b0;
        program_cs_n = 1'b1;
        program_addr = 16'h0000;
        load_start   = 1'b0;
        load_data    = 8'h00;
        load_valid   = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_instruction", 32'(instruction), 32'(FILLV));
        check("rst_ready",       32'(load_ready),  32'd0);
        check("rst_hold",        32'(cpu_hold),    32'd1);
        check("rst_done",        32'(load_done),   32'd0);
        check("rst_error",       32'(load_error),  32'd0);

        // Happy path: 07 C0 55 sums to 1C; E4 completes it to zero.
        img = '{8'h07, 8'hC0, 8'h55};
        run_load(img, 8'hE4);
        fetch(16'd0); fetch(16'd1); fetch(16'd2);
        fetch(16'h0100);
        fetch(16'd1);
        fetch_end();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cs_high_hold", 32'(instruction), 32'(last_instr));
        end

        // Bad checksum.
        run_load(img, 8'hE5);
        fetch(16'd0);
        fetch_end();

        // Overflow: 17 bytes into a 16-byte memory, checksum otherwise correct.
        img = {};
        for (int i = 0; i < 17; i++) img.push_back(8'h01);
        run_load(img, 8'hEF);

        // Zero-length load releases the core and exposes the overflow image.
        run_load(empty_img, 8'h00);
        for (int a = 0; a <= 16; a++) fetch(16'(a));
        fetch_end();

        // Restart mid-load, then a full good image.
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        partial_load(img, 2);
        img = '{8'h0E, 8'h07, 8'h03};
        run_load(img, 8'hE8);
        fetch(16'd0); fetch(16'd1); fetch(16'd2);
        fetch(16'd1);
        fetch_end();

        // Asynchronous reset in the middle of a payload.
        img = {};
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        partial_load(img, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_instruction", 32'(instruction), 32'(FILLV));
        check("arst_ready",       32'(load_ready),  32'd0);
        check("arst_hold",        32'(cpu_hold),    32'd1);
        check("arst_done",        32'(load_done),   32'd0);
        check("arst_error",       32'(load_error),  32'd0);
        m_hold = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_load(empty_img, 8'h00);
        for (int a = 0; a < 6; a++) fetch(16'(a));
        fetch_end();

        // Randomized images: lengths straddle the memory depth, checksums mostly correct.
        for (int it = 0; it < 25; it++) begin
            img  = {};
            rsum = 8'h00;
            for (int i = 0; i < int'($urandom_range(0, 20)); i++) begin
                img.push_back(8'($urandom));
                rsum = rsum + img[i];
            end
            rcs = ($urandom_range(0, 3) != 0) ? 8'(-rsum) : 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                partial_load(img, (img.size() > 1) ? 1 : 0);
            end
            run_load(img, rcs);
            for (int f = 0; f < 4; f++) begin
                case ($urandom_range(0, 3))
                    0:       fetch(16'($urandom_range(16, 300)));
                    default: fetch(16'($urandom_range(0, DEPTH - 1)));
                endcase
            end
            fetch_end();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
